rca_pipe_adder: RTL and testbench

- Parametrised, pipelined successor to the 4-bit ripple-carry adder.
- Splits a WIDTH-bit add/subtract into CHUNK-bit ripple-carry slices, one slice per pipeline stage; the carry is registered between stages.
- Valid/ready handshake on both sides with per-stage bubble collapsing.
- Sits between operand producers and result consumers in the datapath; sustains one operation per cycle.

---
 rtl/rca_pipe_adder.sv | 158 +++++++++++++++
 tb/tb_rca_pipe_adder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rca_pipe_adder.sv
// Pipelined ripple-carry adder/subtractor. Each stage adds one CHUNK-bit slice and
// registers its carry for the next stage. Valid/ready flow control collapses bubbles.
module rca_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int STAGES = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;

  if ((CHUNK < 1) || ((WIDTH % ((CHUNK >= 1) ? CHUNK : 1)) != 0)) begin : g_bad_param
    $error("rca_pipe_adder: WIDTH must be a positive multiple of CHUNK");
  end

  function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             ci);
    logic             c;
    logic [CHUNK-1:0] s;
    c = ci;
    s = '0;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_ld;
  logic              w_full;
  logic              w_in_fire;
  logic [WIDTH-1:0]  w_beff;
  logic              w_c0;

  // A stage advances when it is valid and either the output accepts or some
  // later stage is empty, so the stalled run behind it can compress.
  always_comb begin
    w_adv  = '0;
    w_full = 1'b1;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_adv[k] = r_v[k] & (out_ready | ~w_full);
      w_full   = w_full & r_v[k];
    end
  end

  assign in_ready  = ~r_v[0] | w_adv[0];
  assign w_in_fire = in_valid & in_ready;
  assign w_ld      = (w_adv << 1) | STAGES'(w_in_fire);
  assign out_valid = r_v[STAGES-1];
  assign busy      = |r_v;

  assign w_beff = sub ? ~b : b;
  assign w_c0   = sub | cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
    end else begin
      r_v <= w_ld | (r_v & ~w_adv);
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int REM = WIDTH - (k + 1) * CHUNK;

    logic [CHUNK-1:0]       w_x;
    logic [CHUNK-1:0]       w_y;
    logic                   w_ci;
    logic [CHUNK:0]         w_res;
    logic [(k+1)*CHUNK-1:0] w_s_nxt;
    logic [(k+1)*CHUNK-1:0] r_s;
    logic                   r_c;

    // Stage boundary: stage 0 takes the raw operands, later stages take the
    // previous stage's remaining operand bits, partial sum and carry.
    if (k == 0) begin : g_src
      assign w_x     = a[CHUNK-1:0];
      assign w_y     = w_beff[CHUNK-1:0];
      assign w_ci    = w_c0;
      assign w_s_nxt = w_res[CHUNK-1:0];
    end else begin : g_src
      assign w_x     = g_st[k-1].g_op.r_a[CHUNK-1:0];
      assign w_y     = g_st[k-1].g_op.r_b[CHUNK-1:0];
      assign w_ci    = g_st[k-1].r_c;
      assign w_s_nxt = {w_res[CHUNK-1:0], g_st[k-1].r_s};
    end

    assign w_res = add_chunk(w_x, w_y, w_ci);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s <= '0;
        r_c <= 1'b0;
      end else if (w_ld[k]) begin
        r_s <= w_s_nxt;
        r_c <= w_res[CHUNK];
      end
    end

    if (REM > 0) begin : g_op
      logic [REM-1:0] w_a_up;
      logic [REM-1:0] w_b_up;
      logic [REM-1:0] r_a;
      logic [REM-1:0] r_b;

      if (k == 0) begin : g_up
        assign w_a_up = a[WIDTH-1:CHUNK];
        assign w_b_up = w_beff[WIDTH-1:CHUNK];
      end else begin : g_up
        assign w_a_up = g_st[k-1].g_op.r_a[WIDTH-k*CHUNK-1:CHUNK];
        assign w_b_up = g_st[k-1].g_op.r_b[WIDTH-k*CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_ld[k]) begin
          r_a <= w_a_up;
          r_b <= w_b_up;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic r_ovf;
      // Carry into the MSB is recovered as x ^ y ^ s at the top bit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_ld[k]) begin
          r_ovf <= w_res[CHUNK] ^ w_x[CHUNK-1] ^ w_y[CHUNK-1] ^ w_res[CHUNK-1];
        end
      end
    end
  end

  assign sum  = g_st[STAGES-1].r_s;
  assign cout = g_st[STAGES-1].r_c;
  assign ovf  = g_st[STAGES-1].g_last.r_ovf;

endmodule

// File: tb/tb_rca_pipe_adder.sv
// Directed bench for rca_pipe_adder (WIDTH=16, CHUNK=4) with a queue scoreboard
// filled on input transfers and drained on output transfers.
module tb_rca_pipe_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   acc;
  logic [W+1:0] held;

  rca_pipe_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic s);
    exp_t         e;
    logic [W-1:0] yy;
    logic [W:0]   f;
    yy  = s ? ~y : y;
    f   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (s ? 1'b1 : ci)};
    e.s = f[W-1:0];
    e.c = f[W];
    e.o = (x[W-1] == yy[W-1]) && (f[W-1] != x[W-1]);
    return e;
  endfunction

  // Scoreboard: pop on output transfer, push on input transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("res_sum", 32'(sum), 32'(mon_e.s));
        check("res_cout", 32'(cout), 32'(mon_e.c));
        check("res_ovf", 32'(ovf), 32'(mon_e.o));
      end
    end
    if (rst_n && in_valid && in_ready) sb.push_back(model(a, b, cin, sub));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                         input logic s, input logic [W-1:0] es, input logic ec,
                         input logic eo, input string tag);
    int n;
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check({tag, "_latency"}, 32'(n), 32'd4);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_one(16'h0009, 16'h000B, 1'b0, 1'b0, 16'h0014, 1'b0, 1'b0, "t1");
    run_one(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "t2_ripple");
    run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "t2_ovf");
    run_one(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, "t3_sub_ovf");
    run_one(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "t3_borrow");

    for (int i = 0; i < 8; i++) begin
      a = 16'(i); b = 16'(2 * i); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      check("t4_in_ready", 32'(in_ready), 32'd1);
      if (i >= 4) check("t4_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_tail_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("t4_done_valid", 32'(out_valid), 32'd0);
    check("t4_done_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    out_ready = 1'b0;
    acc = 0;
    held = '0;
    for (int i = 0; i < 6; i++) begin
      a = 16'h1111 * 16'(i + 1); b = 16'h0F0F; cin = 1'b1; sub = (i % 2 == 1);
      in_valid = 1'b1;
      @(negedge clk);
      check("t5_in_ready", 32'(in_ready), 32'(i < 4));
      if (in_ready) acc++;
      if (i >= 4) check("t5_out_valid", 32'(out_valid), 32'd1);
      if (i == 4) held = {sum, cout, ovf};
      if (i == 5) check("t5_hold", 32'({sum, cout, ovf}), 32'(held));
      @(posedge clk); #1;
    end
    check("t5_accepted", 32'(acc), 32'd4);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_drain_valid", 32'(out_valid), 32'd1);
      if (i == 0) check("t5_ready_back", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("t5_empty_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      a = 16'h0100 + 16'(i); b = 16'h0200; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #2;
    check("t6_pre_valid", 32'(out_valid), 32'd1);
    check("t6_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_sum", 32'(sum), 32'd0);
    check("t6_rst_cout", 32'(cout), 32'd0);
    check("t6_rst_ovf", 32'(ovf), 32'd0);
    check("t6_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t6_quiet_valid", 32'(out_valid), 32'd0);
      check("t6_quiet_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
    end
    run_one(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, "t6_new");

    repeat (2) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
